// File: rtl/i2s_tdm_clkgen.sv
// I2S/TDM bit-clock and frame-sync generator with run-time divider and frame-aligned stop.
// Mode 2 (DSP frame pulse) is compiled in only when I2S_TDM_CLKGEN_DSP_EN is defined.
module i2s_tdm_clkgen #(
    parameter int SLOT_BITS = 32,
    parameter int NUM_SLOTS = 2,
    parameter int DIV_W     = 4,
    parameter int BIT_W     = 5,
    parameter int SLOT_W    = 1
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        mode,
    output logic              bclk,
    output logic              wclk,
    output logic              bit_stb,
    output logic              frame_stb,
    output logic [SLOT_W-1:0] slot,
    output logic [BIT_W-1:0]  bit_idx,
    output logic              busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    typedef enum logic [1:0] {FMT_LJ, FMT_I2S, FMT_DSP} fmt_t;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(NUM_SLOTS / 2);

    function automatic fmt_t decode_fmt(input logic [1:0] m);
        fmt_t f;
        f = FMT_LJ;
        if (m == 2'd1) f = FMT_I2S;
`ifdef I2S_TDM_CLKGEN_DSP_EN
        else if (m == 2'd2) f = FMT_DSP;
`endif
        return f;
    endfunction

    // Frame-clock level while the bit at (s, b) is on the wire.
    function automatic logic wclk_level(input logic [SLOT_W-1:0] s,
                                        input logic [BIT_W-1:0]  b,
                                        input fmt_t              f);
        logic [SLOT_W-1:0] ns;
        logic              lvl;
        ns = s;
        if (b == LAST_BIT) ns = (s == LAST_SLOT) ? '0 : s + 1'b1;
        lvl = (s >= HALF_SLOT);
        case (f)
            FMT_I2S: lvl = (ns >= HALF_SLOT);
`ifdef I2S_TDM_CLKGEN_DSP_EN
            FMT_DSP: lvl = (s == LAST_SLOT) && (b == LAST_BIT);
`endif
            default: ;
        endcase
        return lvl;
    endfunction

    state_t            state;
    fmt_t              fmt_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  nxt_bit;
    logic [SLOT_W-1:0] nxt_slot;
    logic              wrap;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nxt_bit  = bit_idx + 1'b1;
        nxt_slot = slot;
        if (bit_idx == LAST_BIT) begin
            nxt_bit  = '0;
            nxt_slot = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        end
    end

    assign wrap = (bit_idx == LAST_BIT) && (slot == LAST_SLOT);

    // NOTE: all state uses non-blocking assignments; later assignments in the block override earlier defaults.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fmt_q     <= FMT_LJ;
            div_q     <= '0;
            clk_cnt   <= '0;
            bclk      <= 1'b0;
            wclk      <= 1'b0;
            bit_stb   <= 1'b0;
            frame_stb <= 1'b0;
            slot      <= '0;
            bit_idx   <= '0;
            busy      <= 1'b0;
        end else begin
            bit_stb   <= 1'b0;
            frame_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        div_q   <= div;
                        fmt_q   <= decode_fmt(mode);
                        slot    <= LAST_SLOT;
                        bit_idx <= LAST_BIT;
                        wclk    <= wclk_level(LAST_SLOT, LAST_BIT, decode_fmt(mode));
                        clk_cnt <= '0;
                        bclk    <= 1'b0;
                    end
                end
                default: begin
                    state <= en ? ST_RUN : ST_DRAIN;
                    if (clk_cnt != div_q) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        bclk    <= ~bclk;
                        if (bclk) begin
                            // Stop only on a frame boundary so the last frame is never truncated.
                            if (wrap && !en) begin
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                bclk    <= 1'b0;
                                wclk    <= 1'b0;
                                slot    <= '0;
                                bit_idx <= '0;
                            end else begin
                                slot      <= nxt_slot;
                                bit_idx   <= nxt_bit;
                                bit_stb   <= 1'b1;
                                frame_stb <= wrap;
                                wclk      <= wclk_level(nxt_slot, nxt_bit, fmt_q);
                                if (wrap) div_q <= div;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_tdm_clkgen.sv
// Randomised self-checking bench: two instances (2x32 and 8x16 frames) against a
// bit-position/phase reference model; mode 2 expectations follow I2S_TDM_CLKGEN_DSP_EN.
module tb_i2s_tdm_clkgen;
    localparam int NS_A = 2;
    localparam int SB_A = 32;
    localparam int NS_B = 8;
    localparam int SB_B = 16;

    logic       adc_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic [3:0] div     = 4'd0;
    logic [1:0] mode    = 2'd0;

    logic       a_bclk, a_wclk, a_bit_stb, a_frame_stb, a_busy;
    logic [0:0] a_slot;
    logic [4:0] a_bit_idx;
    logic       b_bclk, b_wclk, b_bit_stb, b_frame_stb, b_busy;
    logic [2:0] b_slot;
    logic [3:0] b_bit_idx;

    always #5 adc_clk = ~adc_clk;

    i2s_tdm_clkgen #(.SLOT_BITS(SB_A), .NUM_SLOTS(NS_A), .DIV_W(4), .BIT_W(5), .SLOT_W(1)) dut_a (
        .adc_clk(adc_clk), .rst_n(rst_n), .en(en), .div(div), .mode(mode),
        .bclk(a_bclk), .wclk(a_wclk), .bit_stb(a_bit_stb), .frame_stb(a_frame_stb),
        .slot(a_slot), .bit_idx(a_bit_idx), .busy(a_busy)
    );

    i2s_tdm_clkgen #(.SLOT_BITS(SB_B), .NUM_SLOTS(NS_B), .DIV_W(4), .BIT_W(4), .SLOT_W(3)) dut_b (
        .adc_clk(adc_clk), .rst_n(rst_n), .en(en), .div(div), .mode(mode),
        .bclk(b_bclk), .wclk(b_wclk), .bit_stb(b_bit_stb), .frame_stb(b_frame_stb),
        .slot(b_slot), .bit_idx(b_bit_idx), .busy(b_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position is the bit number within the frame, phase counts
    // adc_clk cycles since that bit started (a bit lasts 2*(div+1) cycles).
    int m_ns[2] = '{NS_A, NS_B};
    int m_sb[2] = '{SB_A, SB_B};
    bit m_run[2];
    bit m_pre[2];
    int m_pos[2];
    int m_ph[2];
    int m_d[2];
    int m_fmt[2];

    function automatic int eff_fmt(input int m);
        if (m == 1) return 1;
`ifdef I2S_TDM_CLKGEN_DSP_EN
        if (m == 2) return 2;
`endif
        return 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int total;
            int np;
            total = m_ns[k] * m_sb[k];
            if (!rst_n) begin
                m_run[k] = 1'b0;
            end else if (!m_run[k]) begin
                if (en) begin
                    m_run[k] = 1'b1;
                    m_pre[k] = 1'b1;
                    m_pos[k] = total - 1;
                    m_ph[k]  = 0;
                    m_d[k]   = int'(div);
                    m_fmt[k] = eff_fmt(int'(mode));
                end
            end else if (m_ph[k] == 2 * m_d[k] + 1) begin
                np = (m_pos[k] + 1) % total;
                if (np == 0 && !en) begin
                    m_run[k] = 1'b0;
                end else begin
                    m_pos[k] = np;
                    m_ph[k]  = 0;
                    m_pre[k] = 1'b0;
                    if (np == 0) m_d[k] = int'(div);
                end
            end else begin
                m_ph[k]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int          total, half, p;
            logic        e_bclk, e_wclk, e_bit, e_frame, e_busy;
            logic [31:0] e_slot, e_idx;
            logic        g_bclk, g_wclk, g_bit, g_frame, g_busy;
            logic [31:0] g_slot, g_idx;
            string       nm;
            nm      = (k == 0) ? "A" : "B";
            total   = m_ns[k] * m_sb[k];
            half    = total / 2;
            p       = m_pos[k];
            e_bclk  = 1'b0;
            e_wclk  = 1'b0;
            e_bit   = 1'b0;
            e_frame = 1'b0;
            e_busy  = 1'b0;
            e_slot  = '0;
            e_idx   = '0;
            if (m_run[k]) begin
                e_busy  = 1'b1;
                e_bclk  = (m_ph[k] > m_d[k]);
                e_bit   = !m_pre[k] && (m_ph[k] == 0);
                e_frame = e_bit && (p == 0);
                e_slot  = 32'(p / m_sb[k]);
                e_idx   = 32'(p % m_sb[k]);
                case (m_fmt[k])
                    1:       e_wclk = (((p + 1) % total) >= half);
                    2:       e_wclk = (p == total - 1);
                    default: e_wclk = (p >= half);
                endcase
            end
            if (k == 0) begin
                g_bclk = a_bclk; g_wclk = a_wclk; g_bit = a_bit_stb; g_frame = a_frame_stb;
                g_busy = a_busy; g_slot = 32'(a_slot); g_idx = 32'(a_bit_idx);
            end else begin
                g_bclk = b_bclk; g_wclk = b_wclk; g_bit = b_bit_stb; g_frame = b_frame_stb;
                g_busy = b_busy; g_slot = 32'(b_slot); g_idx = 32'(b_bit_idx);
            end
            check({nm, ".bclk"},      32'(g_bclk),  32'(e_bclk));
            check({nm, ".wclk"},      32'(g_wclk),  32'(e_wclk));
            check({nm, ".bit_stb"},   32'(g_bit),   32'(e_bit));
            check({nm, ".frame_stb"}, 32'(g_frame), 32'(e_frame));
            check({nm, ".busy"},      32'(g_busy),  32'(e_busy));
            check({nm, ".slot"},      g_slot,       e_slot);
            check({nm, ".bit_idx"},   g_idx,        e_idx);
        end
    endtask

    task automatic cycle();
        @(posedge adc_clk);
        model_step();
        @(negedge adc_clk);
        compare_all();
    endtask

    // Cycles between two consecutive bit strobes of instance A, starting from the next strobe.
    task automatic stb_gap(output int gap);
        int n;
        gap = -1;
        n   = 0;
        cycle();
        while (!a_bit_stb && n < 200) begin cycle(); n++; end
        if (a_bit_stb) begin
            n = 0;
            do begin cycle(); n++; end while (!a_bit_stb && n < 200);
            if (a_bit_stb) gap = n;
        end
    endtask

    task automatic wait_a_pos(input int s, input int b, input int budget, output bit ok);
        int n;
        n = 0;
        while (!(int'(a_slot) == s && int'(a_bit_idx) == b && a_busy) && n < budget) begin cycle(); n++; end
        ok = (int'(a_slot) == s && int'(a_bit_idx) == b && a_busy);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while ((a_busy || b_busy) && n < budget) begin cycle(); n++; end
        ok = !(a_busy || b_busy);
    endtask

    initial begin
        int  rise_at, fs_at, gap, cnt, len;
        bit  ok;

        repeat (3) cycle();
        check("reset.outputs_a", {a_bclk, a_wclk, a_bit_stb, a_frame_stb, a_busy, a_slot, a_bit_idx}, 0);
        rst_n = 1'b1;
        repeat (6) cycle();

        // Start-up latency with div=2.
        div = 4'd2; mode = 2'd0; en = 1'b1;
        rise_at = -1; fs_at = -1;
        for (int n = 1; n <= 40 && fs_at < 0; n++) begin
            cycle();
            if (a_bclk && rise_at < 0) rise_at = n;
            if (a_frame_stb) fs_at = n;
        end
        check("lat.bclk_rise", rise_at, 4);
        check("lat.frame_stb", fs_at, 7);

        // Drop en at slot 0 bit 5: frame completes, then silence.
        wait_a_pos(0, 5, 1000, ok);
        check("drain.reach_pos", 32'(ok), 1);
        en = 1'b0;
        cnt = 0;
        while (a_busy && cnt < 1000) begin cycle(); cnt++; end
        check("drain.busy_fell", 32'(a_busy), 0);
        cnt = 0;
        for (int n = 0; n < 300; n++) begin cycle(); if (a_bit_stb) cnt++; end
        check("drain.no_stb", cnt, 0);
        wait_idle(2000, ok);
        check("drain.idle", 32'(ok), 1);

        // Divider change 1 -> 3 takes effect only at the next frame start.
        div = 4'd1; mode = 2'd1; en = 1'b1;
        cnt = 0;
        while (!a_frame_stb && cnt < 600) begin cycle(); cnt++; end
        check("div.first_frame", 32'(a_frame_stb), 1);
        div = 4'd3;
        stb_gap(gap);
        check("div.old_period", gap, 4);
        cnt = 0;
        while (!a_frame_stb && cnt < 1000) begin cycle(); cnt++; end
        check("div.next_frame", 32'(a_frame_stb), 1);
        stb_gap(gap);
        check("div.new_period", gap, 8);

        // Re-raise en during drain: no gap in busy.
        wait_a_pos(0, 5, 1200, ok);
        check("rerun.reach_pos", 32'(ok), 1);
        en = 1'b0;
        wait_a_pos(1, 0, 1200, ok);
        check("rerun.reach_slot1", 32'(ok), 1);
        en = 1'b1;
        cnt = 0;
        for (int n = 0; n < 600; n++) begin cycle(); if (!a_busy) cnt++; end
        check("rerun.busy_gap", cnt, 0);

        // Reset mid-frame clears everything at the next edge.
        rst_n = 1'b0;
        cycle();
        check("rst.outputs_a", {a_bclk, a_wclk, a_bit_stb, a_frame_stb, a_busy, a_slot, a_bit_idx}, 0);
        check("rst.outputs_b", {b_bclk, b_wclk, b_bit_stb, b_frame_stb, b_busy, b_slot, b_bit_idx}, 0);
        rst_n = 1'b1;
        en = 1'b0;
        repeat (3) cycle();

        // Randomised episodes.
        for (int ep = 0; ep < 16; ep++) begin
            div  = 4'($urandom_range(0, 3));
            mode = (ep == 0) ? 2'd2 : (ep == 1) ? 2'd1 : 2'($urandom_range(0, 3));
            en   = 1'b1;
            len  = $urandom_range(50, 700);
            for (int i = 0; i < len; i++) begin
                cycle();
                if ($urandom_range(0, 199) == 0) div = 4'($urandom_range(0, 3));
                if (ep % 5 == 4 && i == len / 2) begin
                    rst_n = 1'b0;
                    cycle();
                    rst_n = 1'b1;
                end
            end
            en  = 1'b0;
            len = $urandom_range(0, 600);
            for (int i = 0; i < len; i++) begin
                cycle();
                if ($urandom_range(0, 499) == 0) en = 1'b1;
            end
            en = 1'b0;
            wait_idle(3000, ok);
            check("ep.idle", 32'(ok), 1);
            repeat (4) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
